// File: rtl/acc_mem_arbiter.sv
// -----------------------------------------------------------------------------
// acc_mem_arbiter
//
// Shares one Data Memory port between NUM_ACC accelerator control units.
// Level-held read (line fetch) and write (word store) requests are serialised
// through an IDLE -> ISSUE -> [WAIT] -> RESP sequence, granted round-robin, and
// completed with a one-cycle pulse to the granted accelerator. Each
// accelerator's last read line is held in its own buffer until its next read.
//
// Build option:
//   ARB_FIXED_PRIORITY_EN - when defined, the lowest-indexed requester always
//                           wins and no round-robin pointer is built.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   acc_read_en          per-accelerator read request (held until valid pulse)
//   acc_read_addr        packed read addresses, slice i belongs to acc i
//   acc_write_en         per-accelerator write request (held until done pulse)
//   acc_write_addr       packed write addresses
//   acc_write_data       packed write data words
//   acc_read_data        packed per-accelerator read line buffers (registered)
//   acc_read_data_valid  one-hot one-cycle read completion pulse
//   acc_write_done       one-hot one-cycle write completion pulse
//   mem_addr             memory address (valid in the issue cycle)
//   mem_rd_en            memory read strobe
//   mem_wr_en            memory write strobe
//   mem_wr_data          memory write data
//   mem_rd_data          memory read data, valid MEM_READ_LATENCY cycles after
//                        the mem_rd_en cycle
// -----------------------------------------------------------------------------
module acc_mem_arbiter #(
   parameter int NUM_ACC          = 4,
   parameter int ADDR_SIZE        = 16,
   parameter int READ_DATA_SIZE   = 512,
   parameter int WRITE_DATA_SIZE  = 32,
   parameter int MEM_READ_LATENCY = 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_ACC-1:0]                   acc_read_en,
   input  logic [NUM_ACC*ADDR_SIZE-1:0]         acc_read_addr,
   input  logic [NUM_ACC-1:0]                   acc_write_en,
   input  logic [NUM_ACC*ADDR_SIZE-1:0]         acc_write_addr,
   input  logic [NUM_ACC*WRITE_DATA_SIZE-1:0]   acc_write_data,
   output logic [NUM_ACC*READ_DATA_SIZE-1:0]    acc_read_data,
   output logic [NUM_ACC-1:0]                   acc_read_data_valid,
   output logic [NUM_ACC-1:0]                   acc_write_done,
   output logic [ADDR_SIZE-1:0]                 mem_addr,
   output logic                                 mem_rd_en,
   output logic                                 mem_wr_en,
   output logic [WRITE_DATA_SIZE-1:0]           mem_wr_data,
   input  logic [READ_DATA_SIZE-1:0]            mem_rd_data
);

   localparam int IDX_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
   localparam int CNT_W = $clog2(MEM_READ_LATENCY + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

   state_e                     state_q;
   logic [IDX_W-1:0]           grant_q;
   logic                       is_write_q;
   logic [CNT_W-1:0]           cnt_q;
   logic                       rd_en_q;
   logic                       wr_en_q;
   logic [NUM_ACC-1:0]         rd_valid_q;
   logic [NUM_ACC-1:0]         wr_done_q;
   logic [READ_DATA_SIZE-1:0]  rd_buf_q [NUM_ACC];
`ifndef ARB_FIXED_PRIORITY_EN
   logic [IDX_W-1:0]           ptr_q;
`endif

   // ---------------------------------------------------------------------------
   // Requester selection
   // ---------------------------------------------------------------------------
   logic [NUM_ACC-1:0] req;
   logic               any_req;
   logic [IDX_W-1:0]   grant_d;
   logic [IDX_W-1:0]   cand_idx;

   // NOTE: every variable assigned in this block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      req      = acc_read_en | acc_write_en;
      any_req  = |req;
      grant_d  = '0;
      cand_idx = '0;
`ifdef ARB_FIXED_PRIORITY_EN
      // Scan downward so the lowest-indexed requester is the last to write.
      for (int i = NUM_ACC - 1; i >= 0; i--) begin
         cand_idx = IDX_W'(i);
         if (req[cand_idx]) grant_d = cand_idx;
      end
`else
      // Candidates ptr+NUM_ACC (ptr itself, lowest priority) down to ptr+1
      // (highest priority); the last match is the first requester after ptr.
      for (int k = NUM_ACC; k >= 1; k--) begin
         cand_idx = IDX_W'((int'(ptr_q) + k) % NUM_ACC);
         if (req[cand_idx]) grant_d = cand_idx;
      end
`endif
   end

   // ---------------------------------------------------------------------------
   // Granted-slice mux; requesters hold address/data until their pulse.
   // ---------------------------------------------------------------------------
   logic [ADDR_SIZE-1:0]       sel_rd_addr;
   logic [ADDR_SIZE-1:0]       sel_wr_addr;
   logic [WRITE_DATA_SIZE-1:0] sel_wr_data;

   assign sel_rd_addr = acc_read_addr [int'(grant_q)*ADDR_SIZE       +: ADDR_SIZE];
   assign sel_wr_addr = acc_write_addr[int'(grant_q)*ADDR_SIZE       +: ADDR_SIZE];
   assign sel_wr_data = acc_write_data[int'(grant_q)*WRITE_DATA_SIZE +: WRITE_DATA_SIZE];

   assign mem_rd_en   = rd_en_q;
   assign mem_wr_en   = wr_en_q;
   assign mem_addr    = (state_q == ISSUE) ? (is_write_q ? sel_wr_addr : sel_rd_addr) : '0;
   assign mem_wr_data = wr_en_q ? sel_wr_data : '0;

   assign acc_read_data_valid = rd_valid_q;
   assign acc_write_done      = wr_done_q;

   for (genvar i = 0; i < NUM_ACC; i++) begin : g_rd_out
      assign acc_read_data[i*READ_DATA_SIZE +: READ_DATA_SIZE] = rd_buf_q[i];
   end

   // ---------------------------------------------------------------------------
   // Control FSM with registered strobes and completion pulses. The strobe and
   // pulse registers are set on the transition into the cycle they belong to.
   // ---------------------------------------------------------------------------
   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         is_write_q <= 1'b0;
         cnt_q      <= '0;
         rd_en_q    <= 1'b0;
         wr_en_q    <= 1'b0;
         rd_valid_q <= '0;
         wr_done_q  <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
         ptr_q      <= IDX_W'(NUM_ACC - 1);
`endif
         // NOTE: the read buffers are architecturally visible outputs that must
         // read zero after reset, so this storage array is reset too.
         for (int i = 0; i < NUM_ACC; i++) rd_buf_q[i] <= '0;
      end else begin
         rd_en_q    <= 1'b0;
         wr_en_q    <= 1'b0;
         rd_valid_q <= '0;
         wr_done_q  <= '0;
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  grant_q    <= grant_d;
                  // Write wins over a simultaneous read from the same acc.
                  is_write_q <= acc_write_en[grant_d];
                  wr_en_q    <= acc_write_en[grant_d];
                  rd_en_q    <= ~acc_write_en[grant_d];
`ifndef ARB_FIXED_PRIORITY_EN
                  ptr_q      <= grant_d;
`endif
                  state_q    <= ISSUE;
               end
            end
            ISSUE: begin
               if (is_write_q) begin
                  wr_done_q[grant_q] <= 1'b1;
                  state_q            <= RESP;
               end else begin
                  cnt_q   <= CNT_W'(MEM_READ_LATENCY);
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) begin
                  rd_buf_q[grant_q]   <= mem_rd_data;
                  rd_valid_q[grant_q] <= 1'b1;
                  state_q             <= RESP;
               end
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_acc_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_acc_mem_arbiter
//
// Scoreboard bench for acc_mem_arbiter (default round-robin build). Stimulus
// pushes the expected memory issue and the expected completion pulse of each
// transaction into two queues; a monitor on the falling edge pops and compares
// whenever the DUT strobes memory or pulses a requester.
// -----------------------------------------------------------------------------
module tb_acc_mem_arbiter;

   localparam int N   = 4;
   localparam int AW  = 16;
   localparam int RDW = 512;
   localparam int WDW = 32;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [N-1:0]         acc_read_en;
   logic [N*AW-1:0]      acc_read_addr;
   logic [N-1:0]         acc_write_en;
   logic [N*AW-1:0]      acc_write_addr;
   logic [N*WDW-1:0]     acc_write_data;
   logic [N*RDW-1:0]     acc_read_data;
   logic [N-1:0]         acc_read_data_valid;
   logic [N-1:0]         acc_write_done;
   logic [AW-1:0]        mem_addr;
   logic                 mem_rd_en;
   logic                 mem_wr_en;
   logic [WDW-1:0]       mem_wr_data;
   logic [RDW-1:0]       mem_rd_data = '0;

   always #5 clk = ~clk;

   acc_mem_arbiter dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .acc_read_en         (acc_read_en),
      .acc_read_addr       (acc_read_addr),
      .acc_write_en        (acc_write_en),
      .acc_write_addr      (acc_write_addr),
      .acc_write_data      (acc_write_data),
      .acc_read_data       (acc_read_data),
      .acc_read_data_valid (acc_read_data_valid),
      .acc_write_done      (acc_write_done),
      .mem_addr            (mem_addr),
      .mem_rd_en           (mem_rd_en),
      .mem_wr_en           (mem_wr_en),
      .mem_wr_data         (mem_wr_data),
      .mem_rd_data         (mem_rd_data)
   );

   // Memory: one-cycle read latency, line = one byte replicated per address.
   function automatic logic [7:0] byte_of(input logic [AW-1:0] a);
      case (a)
         16'h1000: return 8'hA5;
         16'h2000: return 8'h3C;
         16'h3000: return 8'h11;
         16'h3100: return 8'h22;
         16'h4000: return 8'h77;
         default:  return a[15:8];
      endcase
   endfunction

   always @(posedge clk) if (mem_rd_en) mem_rd_data <= {64{byte_of(mem_addr)}};

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   typedef struct {
      bit             is_write;
      int             acc;
      logic [AW-1:0]  addr;
      logic [WDW-1:0] wdata;
      logic [RDW-1:0] rdata;
      int             iss_cyc;
      int             resp_cyc;
   } exp_t;

   exp_t iss_q[$];
   exp_t resp_q[$];
   int   checks      = 0;
   int   failures    = 0;
   int   resp_count  = 0;

   task automatic check(input string name, input logic [RDW-1:0] act, input logic [RDW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input bit w, input int a, input logic [AW-1:0] ad,
                           input logic [WDW-1:0] wd, input logic [7:0] rb,
                           input int ic, input int rc);
      exp_t e;
      e.is_write = w;
      e.acc      = a;
      e.addr     = ad;
      e.wdata    = wd;
      e.rdata    = {64{rb}};
      e.iss_cyc  = ic;
      e.resp_cyc = rc;
      iss_q.push_back(e);
      resp_q.push_back(e);
   endtask

   exp_t         mon_e;
   logic [N-1:0] mon_onehot;

   always @(negedge clk) begin
      if (mem_rd_en || mem_wr_en) begin
         if (iss_q.size() == 0) begin
            check("unexpected_issue", {mem_rd_en, mem_wr_en}, '0);
         end else begin
            mon_e = iss_q.pop_front();
            check("issue_rd_en", mem_rd_en, !mon_e.is_write);
            check("issue_wr_en", mem_wr_en, mon_e.is_write);
            check("issue_addr",  mem_addr,  mon_e.addr);
            if (mon_e.is_write) check("issue_wdata", mem_wr_data, mon_e.wdata);
            check("issue_cycle", cyc, mon_e.iss_cyc);
         end
      end
      if (|acc_read_data_valid || |acc_write_done) begin
         resp_count++;
         if (resp_q.size() == 0) begin
            check("unexpected_resp", {acc_read_data_valid, acc_write_done}, '0);
         end else begin
            mon_e = resp_q.pop_front();
            mon_onehot = '0;
            mon_onehot[mon_e.acc] = 1'b1;
            check("resp_valid", acc_read_data_valid, mon_e.is_write ? '0 : mon_onehot);
            check("resp_done",  acc_write_done,      mon_e.is_write ? mon_onehot : '0);
            check("resp_cycle", cyc, mon_e.resp_cyc);
            if (!mon_e.is_write)
               check("resp_rdata", acc_read_data[mon_e.acc*RDW +: RDW], mon_e.rdata);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns in the cycle after the n-th completion pulse (an IDLE cycle).
   task automatic wait_resps(input int n, input string name);
      int budget = 200;
      while (resp_count < n && budget > 0) begin
         tick();
         budget--;
      end
      if (resp_count < n) check({name, "_timeout"}, resp_count, n);
   endtask

   task automatic apply_reset();
      rst_n          = 1'b0;
      acc_read_en    = '0;
      acc_write_en   = '0;
      acc_read_addr  = '0;
      acc_write_addr = '0;
      acc_write_data = '0;
      iss_q.delete();
      resp_q.delete();
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------------------------------------------------------------------
   // Directed tests
   // ---------------------------------------------------------------------------
   initial begin
      int t0;
      int base;

      apply_reset();

      // Reset state
      check("rst_rd_en",     mem_rd_en,           '0);
      check("rst_wr_en",     mem_wr_en,           '0);
      check("rst_addr",      mem_addr,            '0);
      check("rst_valid",     acc_read_data_valid, '0);
      check("rst_done",      acc_write_done,      '0);
      check("rst_read_data", acc_read_data[RDW-1:0] | acc_read_data[2*RDW-1:RDW] |
                             acc_read_data[3*RDW-1:2*RDW] | acc_read_data[4*RDW-1:3*RDW], '0);

      // Read latency: acc 1 reads 0x1000
      base = resp_count;
      acc_read_addr[1*AW +: AW] = 16'h1000;
      acc_read_en = 4'b0010;
      t0 = cyc;
      push_exp(1'b0, 1, 16'h1000, '0, 8'hA5, t0 + 1, t0 + 3);
      wait_resps(base + 1, "read");
      acc_read_en = '0;
      check("read_buf0_kept", acc_read_data[0*RDW +: RDW], '0);
      check("read_buf2_kept", acc_read_data[2*RDW +: RDW], '0);
      check("read_buf3_kept", acc_read_data[3*RDW +: RDW], '0);

      // Write: acc 2 writes 0x5 to 0x5000
      base = resp_count;
      acc_write_addr[2*AW  +: AW]  = 16'h5000;
      acc_write_data[2*WDW +: WDW] = 32'h5;
      acc_write_en = 4'b0100;
      t0 = cyc;
      push_exp(1'b1, 2, 16'h5000, 32'h5, 8'h00, t0 + 1, t0 + 2);
      wait_resps(base + 1, "write");
      acc_write_en = '0;
      repeat (3) tick();
      check("read_buf1_after_write", acc_read_data[1*RDW +: RDW], {64{8'hA5}});

      // Fairness: all four hold writes from reset; order 0,1,2,3,0,1
      apply_reset();
      for (int i = 0; i < N; i++) begin
         acc_write_addr[i*AW  +: AW]  = 16'h0100 + 16'(i);
         acc_write_data[i*WDW +: WDW] = 32'hC0DE_0000 + 32'(i);
      end
      base = resp_count;
      acc_write_en = 4'b1111;
      t0 = cyc;
      for (int k = 0; k < 6; k++)
         push_exp(1'b1, k % N, 16'h0100 + 16'(k % N), 32'hC0DE_0000 + 32'(k % N), 8'h00,
                  t0 + 1 + 3 * k, t0 + 2 + 3 * k);
      wait_resps(base + 6, "fairness");
      acc_write_en = '0;
      repeat (2) tick();

      // Same-acc conflict: acc 0 read and write together, write first
      base = resp_count;
      acc_read_addr[0 +: AW]   = 16'h2000;
      acc_write_addr[0 +: AW]  = 16'h2004;
      acc_write_data[0 +: WDW] = 32'hDEAD_BEEF;
      acc_read_en  = 4'b0001;
      acc_write_en = 4'b0001;
      t0 = cyc;
      push_exp(1'b1, 0, 16'h2004, 32'hDEAD_BEEF, 8'h00, t0 + 1, t0 + 2);
      push_exp(1'b0, 0, 16'h2000, '0,            8'h3C, t0 + 4, t0 + 6);
      wait_resps(base + 1, "conflict_write");
      acc_write_en = '0;
      check("conflict_buf0_before_read", acc_read_data[0 +: RDW], '0);
      wait_resps(base + 2, "conflict_read");
      acc_read_en = '0;
      check("conflict_buf0_after_read", acc_read_data[0 +: RDW], {64{8'h3C}});

      // Buffer retention: acc 0 reads 0x11.., then acc 3 reads 0x22..
      base = resp_count;
      acc_read_addr[0 +: AW] = 16'h3000;
      acc_read_en = 4'b0001;
      t0 = cyc;
      push_exp(1'b0, 0, 16'h3000, '0, 8'h11, t0 + 1, t0 + 3);
      wait_resps(base + 1, "retain_acc0");
      acc_read_en = '0;
      base = resp_count;
      acc_read_addr[3*AW +: AW] = 16'h3100;
      acc_read_en = 4'b1000;
      t0 = cyc;
      push_exp(1'b0, 3, 16'h3100, '0, 8'h22, t0 + 1, t0 + 3);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("retain_buf0", acc_read_data[0 +: RDW], {64{8'h11}});
      end
      wait_resps(base + 1, "retain_acc3");
      acc_read_en = '0;
      check("retain_buf0_end", acc_read_data[0*RDW +: RDW], {64{8'h11}});
      check("retain_buf3_end", acc_read_data[3*RDW +: RDW], {64{8'h22}});

      // Reset mid-read: acc 1 reads (acc 2 write waiting), reset lands in WAIT
      acc_read_addr[1*AW   +: AW]  = 16'h4000;
      acc_write_addr[2*AW  +: AW]  = 16'h6000;
      acc_write_data[2*WDW +: WDW] = 32'h66;
      acc_read_en  = 4'b0010;
      acc_write_en = 4'b0100;
      t0 = cyc;
      push_exp(1'b0, 1, 16'h4000, '0, 8'h77, t0 + 1, t0 + 3);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("midrst_rd_en", mem_rd_en,           '0);
      check("midrst_addr",  mem_addr,            '0);
      check("midrst_valid", acc_read_data_valid, '0);
      check("midrst_done",  acc_write_done,      '0);
      check("midrst_buf0",  acc_read_data[0*RDW +: RDW], '0);
      check("midrst_buf1",  acc_read_data[1*RDW +: RDW], '0);
      iss_q.delete();
      resp_q.delete();
      acc_read_en = '0;
      repeat (2) tick();
      base = resp_count;
      rst_n = 1'b1;
      t0 = cyc;
      push_exp(1'b1, 2, 16'h6000, 32'h66, 8'h00, t0 + 1, t0 + 2);
      wait_resps(base + 1, "after_reset");
      acc_write_en = '0;
      repeat (4) tick();
      check("final_buf1", acc_read_data[1*RDW +: RDW], '0);
      check("final_pending", iss_q.size() + resp_q.size(), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
